// File: rtl/seg_scan_if.sv
// Host-side write bus and live blanking mask for the seven-segment scan controller.
// The host drives through the master modport and the scan controller samples through the slave modport.
interface seg_scan_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        load_all;
    logic [31:0] load_data;
    logic [7:0]  blank_mask;

    modport master (
        output wr_en, wr_addr, wr_data, load_all, load_data, blank_mask
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load_all, load_data, blank_mask
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with a double-buffered digit bank.
// Host writes land in the shadow bank, which is copied to the displayed bank only at frame wrap.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    seg_scan_if.slave   host,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        digit_en,
    output logic        pending,
    output logic        frame_done
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    sel_next;
    logic          commit;
    logic          write;
    logic [31:0]   shadow;
    logic [31:0]   shadow_next;
    logic [31:0]   active;
    logic [31:0]   active_next;

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        sel_next = tick ? sel + 3'd1 : sel;
        commit   = tick && (sel == 3'd7) && pending;
        write    = host.wr_en || host.load_all;

        // The commit takes the shadow as registered, so a write in the same cycle waits a frame.
        active_next = commit ? shadow : active;

        shadow_next = shadow;
        if (host.load_all) begin
            shadow_next = host.load_data;
        end
        if (host.wr_en) begin
            shadow_next[{host.wr_addr, 2'b00} +: 4] = host.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sel     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            sel     <= sel_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shadow     <= shadow_next;
            active     <= active_next;
            frame_done <= commit;
            if (write) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Outputs look ahead to sel_next so num, sel and digit_en all move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num      <= '0;
            digit_en <= 1'b0;
        end else begin
            num      <= active_next[{sel_next, 2'b00} +: 4];
            digit_en <= ~host.blank_mask[sel_next];
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed-plus-random bench for seg_scan_ctrl at REFRESH_DIV=4 and REFRESH_DIV=1, side by side.
// Expected outputs come from an edge-count model: slot = edge/DIV, digit = slot mod 8, wrap every 8*DIV edges.
module tb_seg_scan_ctrl;
    logic clk = 1'b0;
    logic reset;

    seg_scan_if if4 ();
    seg_scan_if if1 ();

    logic [3:0] num4, num1;
    logic [2:0] sel4, sel1;
    logic       en4, en1, pend4, pend1, fd4, fd1;

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .host(if4.slave),
        .num(num4), .sel(sel4), .digit_en(en4), .pending(pend4), .frame_done(fd4)
    );

    seg_scan_ctrl #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .host(if1.slave),
        .num(num1), .sel(sel1), .digit_en(en1), .pending(pend1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         divs [2] = '{4, 1};
    int         k    [2];
    logic [3:0] sh   [2][8];
    logic [3:0] ac   [2][8];
    bit         pend [2];
    int         fd_seen [2];

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, got, exp);
        end
    endtask

    function automatic logic [9:0] obs(input int d);
        return (d == 0) ? {sel4, num4, en4, pend4, fd4} : {sel1, num1, en1, pend1, fd1};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            k[d]       = 0;
            pend[d]    = 1'b0;
            fd_seen[d] = 0;
            for (int i = 0; i < 8; i++) begin
                sh[d][i] = 4'h0;
                ac[d][i] = 4'h0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) chk(tag, d, {22'd0, obs(d)}, 32'd0);
    endtask

    // One clock edge: capture what the DUTs see, advance the model, compare, then drop write strobes.
    task automatic step();
        logic        we [2];
        logic [2:0]  wa [2];
        logic [3:0]  wd [2];
        logic        la [2];
        logic [31:0] ld [2];
        logic [7:0]  bm [2];
        we[0] = if4.wr_en; wa[0] = if4.wr_addr; wd[0] = if4.wr_data;
        la[0] = if4.load_all; ld[0] = if4.load_data; bm[0] = if4.blank_mask;
        we[1] = if1.wr_en; wa[1] = if1.wr_addr; wd[1] = if1.wr_data;
        la[1] = if1.load_all; ld[1] = if1.load_data; bm[1] = if1.blank_mask;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit         commit;
            int         es;
            logic [9:0] o;
            k[d]++;
            commit = (k[d] % divs[d] == 0) && ((k[d] / divs[d]) % 8 == 0) && pend[d];
            if (commit) begin
                for (int i = 0; i < 8; i++) ac[d][i] = sh[d][i];
                pend[d] = 1'b0;
            end
            if (la[d]) for (int i = 0; i < 8; i++) sh[d][i] = ld[d][4*i +: 4];
            if (we[d]) sh[d][wa[d]] = wd[d];
            if (la[d] || we[d]) pend[d] = 1'b1;
            es = (k[d] / divs[d]) % 8;
            o  = obs(d);
            fd_seen[d] += int'(o[0]);
            chk("sel",        d, {29'd0, o[9:7]}, es);
            chk("num",        d, {28'd0, o[6:3]}, {28'd0, ac[d][es]});
            chk("digit_en",   d, {31'd0, o[2]},   {31'd0, ~bm[d][es]});
            chk("pending",    d, {31'd0, o[1]},   {31'd0, pend[d]});
            chk("frame_done", d, {31'd0, o[0]},   {31'd0, commit});
        end
        if4.wr_en = 1'b0; if4.load_all = 1'b0;
        if1.wr_en = 1'b0; if1.load_all = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        if4.wr_en = 1'b0; if4.wr_addr = '0; if4.wr_data = '0;
        if4.load_all = 1'b0; if4.load_data = '0; if4.blank_mask = '0;
        if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
        if1.load_all = 1'b0; if1.load_data = '0; if1.blank_mask = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;

        // Idle scan: a full frame and a wrap with no commit.
        run(36);
        chk("idle_no_fd", 0, fd_seen[0], 0);

        // Bulk load mid-frame at slot 3; commit at the next wrap.
        for (int g = 0; g < 64 && ((k[0] / 4) % 8) != 3; g++) step();
        if4.load_all  = 1'b1;
        if4.load_data = 32'h89AB_CDEF;
        step();
        for (int g = 0; g < 64 && fd_seen[0] == 0; g++) step();
        chk("load_fd_cnt", 0, fd_seen[0], 1);
        chk("load_slot0", 0, {28'd0, num4}, 32'hF);
        run(32);

        // Zero bank with a single overriding nibble write in the same cycle.
        if4.load_all  = 1'b1;
        if4.load_data = 32'h0;
        if4.wr_en     = 1'b1;
        if4.wr_addr   = 3'd2;
        if4.wr_data   = 4'h5;
        step();
        run(40);

        // Write landing exactly on the commit edge waits for the following wrap.
        if4.wr_en = 1'b1; if4.wr_addr = 3'd3; if4.wr_data = 4'h7;
        step();
        for (int g = 0; g < 64 && (k[0] % 32) != 31; g++) step();
        if4.wr_en = 1'b1; if4.wr_addr = 3'd0; if4.wr_data = 4'hA;
        step();
        chk("commit_edge_pending", 0, {31'd0, pend4}, 32'd1);
        chk("commit_edge_old", 0, {28'd0, num4}, 32'h0);
        run(40);

        // Live blanking, including a mid-slot change.
        if4.blank_mask = 8'h0F;
        if1.blank_mask = 8'h0F;
        run(33);
        if4.blank_mask = 8'hF0;
        step();
        if4.blank_mask = 8'h00;
        if1.blank_mask = 8'h00;
        run(6);

        // Async reset mid-frame with a pending write at slot 5.
        if4.wr_en = 1'b1; if4.wr_addr = 3'd5; if4.wr_data = 4'h9;
        if1.load_all = 1'b1; if1.load_data = 32'h1234_5678;
        step();
        for (int g = 0; g < 64 && ((k[0] / 4) % 8) != 5; g++) step();
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        run(40);
        chk("post_reset_no_fd", 0, fd_seen[0], 0);

        // REFRESH_DIV=1 commit on the 7->0 edge.
        if1.load_all = 1'b1; if1.load_data = 32'hFEDC_BA98;
        step();
        run(12);
        chk("div1_fd", 1, fd_seen[1], 1);

        // Randomized writes, bulk loads and blanking on both instances.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if4.wr_en = 1'b1; if4.wr_addr = 3'($urandom); if4.wr_data = 4'($urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                if4.load_all = 1'b1; if4.load_data = $urandom;
            end
            if ($urandom_range(0, 4) == 0) begin
                if1.wr_en = 1'b1; if1.wr_addr = 3'($urandom); if1.wr_data = 4'($urandom);
            end
            if ($urandom_range(0, 14) == 0) begin
                if1.load_all = 1'b1; if1.load_data = $urandom;
            end
            if ($urandom_range(0, 49) == 0) if4.blank_mask = 8'($urandom);
            if ($urandom_range(0, 49) == 0) if1.blank_mask = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
